// File: rtl/pc_stack_unit_if.sv
// rtl/pc_stack_unit_if.sv - control and status bundle between the CPU core and the PC/return-stack unit
interface pc_stack_unit_if;
  logic       en;
  logic [1:0] op;
  logic [7:0] target;
  logic       clr_fault;
  logic [7:0] pc;
  logic [2:0] sp;
  logic [7:0] ret_top;
  logic       stack_empty;
  logic       stack_full;
  logic       fault;

  modport master (
    output en, op, target, clr_fault,
    input  pc, sp, ret_top, stack_empty, stack_full, fault
  );

  modport slave (
    input  en, op, target, clr_fault,
    output pc, sp, ret_top, stack_empty, stack_full, fault
  );
endinterface

// File: rtl/pc_stack_unit.sv
// rtl/pc_stack_unit.sv - registered 8-bit program counter with a small hardware return stack
// Stack overflow/underflow degrade to INC and raise a sticky fault.
module pc_stack_unit #(
  parameter int         STACK_DEPTH = 4,
  parameter logic [7:0] RESET_PC    = 8'h00
) (
  input logic           clk,
  input logic           rst_n,
  pc_stack_unit_if.slave bus
);

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  logic [7:0] pc_q;
  logic [2:0] sp_q;
  logic [7:0] stack_q [STACK_DEPTH];
  logic       fault_q;

  logic [7:0] pc_inc;
  logic [7:0] ret_top_c;
  logic       empty_c;
  logic       full_c;
  logic       overflow;
  logic       underflow;

  assign pc_inc    = pc_q + 8'd1;
  assign empty_c   = (sp_q == 3'd0);
  assign full_c    = (sp_q == 3'(STACK_DEPTH));
  assign overflow  = bus.en && (bus.op == OP_CALL) && full_c;
  assign underflow = bus.en && (bus.op == OP_RET) && empty_c;

  // Decoded by comparison rather than indexing so sp's 3 bits never over-address the array.
  always_comb begin
    ret_top_c = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == 3'(i + 1)) ret_top_c = stack_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      sp_q    <= 3'd0;
      fault_q <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= 8'h00;
    end else begin
      if (bus.en) begin
        case (bus.op)
          OP_INC: pc_q <= pc_inc;
          OP_JMP: pc_q <= bus.target;
          OP_CALL: begin
            if (full_c) begin
              pc_q <= pc_inc;
            end else begin
              for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == 3'(i)) stack_q[i] <= pc_inc;
              end
              sp_q <= sp_q + 3'd1;
              pc_q <= bus.target;
            end
          end
          OP_RET: begin
            if (empty_c) begin
              pc_q <= pc_inc;
            end else begin
              pc_q <= ret_top_c;
              sp_q <= sp_q - 3'd1;
            end
          end
          default: pc_q <= pc_inc;
        endcase
      end
      // A new fault in the same cycle as clr_fault wins.
      if (overflow || underflow) begin
        fault_q <= 1'b1;
      end else if (bus.clr_fault) begin
        fault_q <= 1'b0;
      end
    end
  end

  assign bus.pc          = pc_q;
  assign bus.sp          = sp_q;
  assign bus.ret_top     = ret_top_c;
  assign bus.stack_empty = empty_c;
  assign bus.stack_full  = full_c;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb/tb_pc_stack_unit.sv - directed plus randomized check of pc_stack_unit against a queue-based model
module tb_pc_stack_unit;

  localparam int         DEPTH = 4;
  localparam logic [7:0] RPC   = 8'h00;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [7:0] m_pc;
  logic [7:0] m_stack [$];
  logic       m_fault;

  pc_stack_unit_if bus ();

  pc_stack_unit #(.STACK_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RPC;
    m_stack.delete();
    m_fault = 1'b0;
  endtask

  task automatic model_apply(input logic e, input logic [1:0] o, input logic [7:0] t, input logic c);
    logic hit;
    hit = 1'b0;
    if (e) begin
      case (o)
        2'b00: m_pc = m_pc + 8'd1;
        2'b01: m_pc = t;
        2'b10: begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back(m_pc + 8'd1);
            m_pc = t;
          end else begin
            hit = 1'b1;
            m_pc = m_pc + 8'd1;
          end
        end
        default: begin
          if (m_stack.size() > 0) begin
            m_pc = m_stack.pop_back();
          end else begin
            hit = 1'b1;
            m_pc = m_pc + 8'd1;
          end
        end
      endcase
    end
    if (hit) m_fault = 1'b1;
    else if (c) m_fault = 1'b0;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_top;
    exp_top = (m_stack.size() > 0) ? m_stack[$] : 8'h00;
    check_val({tag, "_pc"},    bus.pc, m_pc);
    check_val({tag, "_sp"},    bus.sp, m_stack.size());
    check_val({tag, "_top"},   bus.ret_top, exp_top);
    check_val({tag, "_empty"}, bus.stack_empty, m_stack.size() == 0);
    check_val({tag, "_full"},  bus.stack_full, m_stack.size() == DEPTH);
    check_val({tag, "_fault"}, bus.fault, m_fault);
  endtask

  task automatic step(input string tag, input logic e, input logic [1:0] o, input logic [7:0] t, input logic c);
    bus.en = e;
    bus.op = o;
    bus.target = t;
    bus.clr_fault = c;
    @(posedge clk);
    model_apply(e, o, t, c);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    bus.en = 1'b0;
    bus.op = 2'b00;
    bus.target = 8'h00;
    bus.clr_fault = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // 1: increment and wrap
    for (int i = 0; i < 3; i++) step("t1_inc", 1'b1, 2'b00, 8'h00, 1'b0);
    check_val("t1_pc3", bus.pc, 8'h03);
    step("t1_jmp", 1'b1, 2'b01, 8'hFF, 1'b0);
    step("t1_wrap", 1'b1, 2'b00, 8'h00, 1'b0);
    check_val("t1_wrap_pc", bus.pc, 8'h00);

    // 2: single call/return
    step("t2_jmp", 1'b1, 2'b01, 8'h10, 1'b0);
    step("t2_call", 1'b1, 2'b10, 8'h40, 1'b0);
    check_val("t2_call_top", bus.ret_top, 8'h11);
    step("t2_inc", 1'b1, 2'b00, 8'h00, 1'b0);
    step("t2_inc", 1'b1, 2'b00, 8'h00, 1'b0);
    step("t2_ret", 1'b1, 2'b11, 8'h00, 1'b0);
    check_val("t2_ret_pc", bus.pc, 8'h11);

    // 3: nesting to full, overflow, LIFO unwind
    step("t3_jmp", 1'b1, 2'b01, 8'h05, 1'b0);
    for (int i = 0; i < 4; i++) step("t3_call", 1'b1, 2'b10, 8'(8'h20 + 8'h10 * i), 1'b0);
    check_val("t3_full", bus.stack_full, 1'b1);
    step("t3_ovf", 1'b1, 2'b10, 8'h60, 1'b0);
    check_val("t3_ovf_pc", bus.pc, 8'h51);
    check_val("t3_ovf_fault", bus.fault, 1'b1);
    step("t3_ret", 1'b1, 2'b11, 8'h00, 1'b0);
    check_val("t3_ret1", bus.pc, 8'h41);
    step("t3_ret", 1'b1, 2'b11, 8'h00, 1'b0);
    step("t3_ret", 1'b1, 2'b11, 8'h00, 1'b0);
    step("t3_ret", 1'b1, 2'b11, 8'h00, 1'b0);
    check_val("t3_ret4", bus.pc, 8'h06);

    // 4: underflow and set-wins-over-clear
    step("t4_clr", 1'b1, 2'b01, 8'h7F, 1'b1);
    step("t4_udf", 1'b1, 2'b11, 8'h00, 1'b0);
    check_val("t4_udf_pc", bus.pc, 8'h80);
    step("t4_setwin", 1'b1, 2'b11, 8'h00, 1'b1);
    check_val("t4_setwin_fault", bus.fault, 1'b1);
    step("t4_clr_inc", 1'b1, 2'b00, 8'h00, 1'b1);
    check_val("t4_cleared", bus.fault, 1'b0);

    // 5: stall holds state, clr_fault still acts
    step("t5_call", 1'b1, 2'b10, 8'h33, 1'b0);
    step("t5_ovf_prep", 1'b1, 2'b11, 8'h00, 1'b0);
    step("t5_udf", 1'b1, 2'b11, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) step("t5_stall", 1'b0, 2'b10, 8'hAA, 1'b0);
    step("t5_stall_clr", 1'b0, 2'b10, 8'hAA, 1'b1);
    check_val("t5_clr_fault", bus.fault, 1'b0);

    // 6: asynchronous reset in the middle of a call chain
    step("t6_call", 1'b1, 2'b10, 8'h90, 1'b0);
    step("t6_call", 1'b1, 2'b10, 8'hA0, 1'b0);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("t6_async");
    check_val("t6_async_pc", bus.pc, RPC);
    @(negedge clk);
    rst_n = 1'b1;
    step("t6_udf", 1'b1, 2'b11, 8'h00, 1'b0);
    check_val("t6_udf_fault", bus.fault, 1'b1);

    // random traffic biased toward calls/returns so both stack limits are exercised
    for (int i = 0; i < 1500; i++) begin
      logic [1:0] o;
      int r;
      r = $urandom_range(0, 9);
      o = (r < 2) ? 2'b00 : (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
      step("rnd", ($urandom_range(0, 7) != 0), o, 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
